// File: rtl/uimac_pkg.sv
// Shared constants, state encoding and byte-wide CRC32 step for the uimac transmit path.
package uimac_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE         = 8'hd5;
  localparam logic [31:0] CRC_POLY         = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT         = 32'hFFFFFFFF;
  localparam logic [15:0] ARP_TYPE         = 16'h0806;
  localparam logic [15:0] IP_TYPE          = 16'h0800;
  localparam logic [15:0] MAC_CONTROL_TYPE = 16'h8808;

  localparam int MIN_PAYLOAD_DEF = 46;
  localparam int MAX_PAYLOAD_DEF = 1500;
  localparam int IFG_BYTES_DEF   = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_e;

  // Reflected CRC32: bytes enter LSB first, so the polynomial is bit-reversed.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    logic [31:0] poly_r;
    for (int i = 0; i < 32; i++) poly_r[i] = CRC_POLY[31-i];
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/uimac_tx_framer_if.sv
// Upper-layer request/data handshake, pause inputs and GMII transmit outputs of the framer.
interface uimac_tx_framer_if;
  logic [47:0] I_mac_local_addr;
  logic [47:0] I_mac_dst_addr;
  logic [15:0] I_mac_ttype;
  logic [10:0] I_mac_tlen;
  logic        I_mac_treq;
  logic        O_mac_tack;
  logic        O_mac_tdata_rd;
  logic [7:0]  I_mac_tdata;
  logic        O_mac_tdone;
  logic        I_mac_pause_en;
  logic [21:0] I_mac_pause_time;
  logic        O_gmii_tvalid;
  logic [7:0]  O_gmii_tdata;

  modport master (
    output I_mac_local_addr, I_mac_dst_addr, I_mac_ttype, I_mac_tlen, I_mac_treq,
    output I_mac_tdata, I_mac_pause_en, I_mac_pause_time,
    input  O_mac_tack, O_mac_tdata_rd, O_mac_tdone, O_gmii_tvalid, O_gmii_tdata
  );

  modport slave (
    input  I_mac_local_addr, I_mac_dst_addr, I_mac_ttype, I_mac_tlen, I_mac_treq,
    input  I_mac_tdata, I_mac_pause_en, I_mac_pause_time,
    output O_mac_tack, O_mac_tdata_rd, O_mac_tdone, O_gmii_tvalid, O_gmii_tdata
  );
endinterface

// File: rtl/crc32_gen.sv
// Ethernet CRC32 accumulator, one byte per cycle; init reloads the seed, en folds in data.
module crc32_gen
  import uimac_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] r_crc;
  logic [31:0] w_crc_nxt;

  assign w_crc_nxt = crc32_byte(r_crc, data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_crc <= CRC_INIT;
    else if (init) r_crc <= CRC_INIT;
    else if (en)   r_crc <= w_crc_nxt;
  end

  assign crc = r_crc;

endmodule

// File: rtl/uimac_tx_framer.sv
// GMII transmit framer: preamble/SFD, MAC header, payload, zero pad, FCS, inter-frame gap.
// Define UIMAC_TX_PAUSE_EN to build the PAUSE counter that holds off frame start.
module uimac_tx_framer
  import uimac_pkg::*;
#(
  parameter int IFG_BYTES   = IFG_BYTES_DEF,
  parameter int MIN_PAYLOAD = MIN_PAYLOAD_DEF,
  parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEF
) (
  input logic              I_gmii_tclk,
  input logic              I_reset_n,
  uimac_tx_framer_if.slave bus
);

  localparam logic [15:0] MIN_P    = 16'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_P    = 11'(MAX_PAYLOAD);
  // The IDLE accept cycle and the tack cycle also show tvalid=0, so the state itself is shorter.
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 2);

  tx_state_e    r_state, w_state_nxt;
  logic [15:0]  r_cnt;
  logic         r_tack, r_tvalid, r_tdone;
  logic [7:0]   r_tdata;
  logic [47:0]  r_dst;
  logic [15:0]  r_type;
  logic [10:0]  r_len;

  logic         w_accept, w_vld, w_rd, w_crc_init, w_crc_en, w_pause_ok;
  logic [7:0]   w_byte;
  logic [31:0]  w_crc, w_fcs;
  logic [111:0] w_hdr;
  logic [6:0]   w_hdr_base;
  logic [15:0]  w_len16, w_pay_last, w_pad_last;

  assign w_len16    = {5'd0, r_len};
  assign w_pay_last = w_len16 - 16'd1;
  assign w_pad_last = MIN_P - w_len16 - 16'd1;
  assign w_hdr      = {r_dst, bus.I_mac_local_addr, r_type};
  assign w_hdr_base = 7'd111 - {r_cnt[3:0], 3'b000};
  assign w_fcs      = ~w_crc;

`ifdef UIMAC_TX_PAUSE_EN
  logic [21:0] r_pause_cnt;

  always_ff @(posedge I_gmii_tclk or negedge I_reset_n) begin
    if (!I_reset_n)                r_pause_cnt <= '0;
    else if (bus.I_mac_pause_en)   r_pause_cnt <= bus.I_mac_pause_time;
    else if (r_pause_cnt != '0)    r_pause_cnt <= r_pause_cnt - 22'd1;
  end

  assign w_pause_ok = (r_pause_cnt == '0);
`else
  assign w_pause_ok = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_vld       = 1'b0;
    w_rd        = 1'b0;
    w_crc_init  = 1'b0;
    w_crc_en    = 1'b0;
    w_byte      = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (bus.I_mac_treq && w_pause_ok) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        w_vld      = 1'b1;
        w_crc_init = 1'b1;
        w_byte     = (r_cnt == 16'd7) ? SFD_BYTE : PREAMBLE_BYTE;
        if (r_cnt == 16'd7) w_state_nxt = ST_HEADER;
      end
      ST_HEADER: begin
        w_vld    = 1'b1;
        w_crc_en = 1'b1;
        w_byte   = w_hdr[w_hdr_base -: 8];
        if (r_cnt == 16'd13) w_state_nxt = (r_len == '0) ? ST_PAD : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        w_vld    = 1'b1;
        w_rd     = 1'b1;
        w_crc_en = 1'b1;
        w_byte   = bus.I_mac_tdata;
        if (r_cnt == w_pay_last) w_state_nxt = (w_len16 < MIN_P) ? ST_PAD : ST_FCS;
      end
      ST_PAD: begin
        w_vld    = 1'b1;
        w_crc_en = 1'b1;
        if (r_cnt == w_pad_last) w_state_nxt = ST_FCS;
      end
      ST_FCS: begin
        w_vld  = 1'b1;
        w_byte = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
        if (r_cnt == 16'd3) w_state_nxt = ST_IFG;
      end
      ST_IFG: begin
        if (r_cnt == IFG_LAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_gmii_tclk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_tack   <= 1'b0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tdone  <= 1'b0;
      r_dst    <= '0;
      r_type   <= '0;
      r_len    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      if (r_state == ST_IDLE || w_state_nxt != r_state) r_cnt <= '0;
      else                                              r_cnt <= r_cnt + 16'd1;
      r_tack   <= w_accept;
      r_tvalid <= w_vld;
      r_tdata  <= w_byte;
      r_tdone  <= (r_state == ST_FCS) && (r_cnt == 16'd3);
      // Upper layer holds its fields until it sees tack, so sample while tack is out.
      if (r_tack) begin
        r_dst  <= bus.I_mac_dst_addr;
        r_type <= bus.I_mac_ttype;
        r_len  <= (bus.I_mac_tlen > MAX_P) ? MAX_P : bus.I_mac_tlen;
      end
    end
  end

  crc32_gen u_crc (
    .clk   (I_gmii_tclk),
    .rst_n (I_reset_n),
    .init  (w_crc_init),
    .en    (w_crc_en),
    .data  (w_byte),
    .crc   (w_crc)
  );

  assign bus.O_mac_tack     = r_tack;
  assign bus.O_mac_tdata_rd = w_rd;
  assign bus.O_mac_tdone    = r_tdone;
  assign bus.O_gmii_tvalid  = r_tvalid;
  assign bus.O_gmii_tdata   = r_tdata;

endmodule

// File: tb/tb_uimac_tx_framer.sv
// Bench for uimac_tx_framer: random frames against a byte-queue frame model with bit-serial CRC.
// Pause expectations follow whether UIMAC_TX_PAUSE_EN is defined.
module tb_uimac_tx_framer;
  import uimac_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [7:0]  pay [0:2047];
  logic [10:0] pidx = '0;
  int tack_cyc = 0, sof_cyc = 0, eof_cyc = -1, p_cyc = 0, r_cyc = 0;
  localparam logic [47:0] LOCAL_MAC = 48'h000a35aabbcc;
`ifdef UIMAC_TX_PAUSE_EN
  localparam bit GAP_AFTER_PAUSE = 1'b0;
`else
  localparam bit GAP_AFTER_PAUSE = 1'b1;
`endif

  uimac_tx_framer_if bus();

  uimac_tx_framer dut (
    .I_gmii_tclk (clk),
    .I_reset_n   (rst_n),
    .bus         (bus.slave)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Show-ahead payload source: current byte always presented, advanced by each rd strobe.
  always @(posedge clk) begin
    if (bus.O_mac_tack)          pidx <= '0;
    else if (bus.O_mac_tdata_rd) pidx <= pidx + 11'd1;
  end
  assign bus.I_mac_tdata = pay[pidx];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] outs();
    return {bus.O_mac_tack, bus.O_mac_tdata_rd, bus.O_mac_tdone, bus.O_gmii_tvalid, bus.O_gmii_tdata};
  endfunction

  task automatic send(input int len, input bit hold, input bit fixed, input int pause_at,
                      input int rel_at, input int abort_at, input bit chk_gap);
    logic [63:0] rnd;
    logic [47:0] dst, src;
    logic [15:0] typ;
    logic [31:0] c, r, fcs_e, fcs_o;
    logic [7:0]  b;
    logic [7:0]  expq[$];
    logic [7:0]  obs[$];
    logic        fb;
    int eff, n, nrd, ndone, done_idx, nmis, sz;

    rnd = {$urandom, $urandom};
    dst = fixed ? 48'h000a35010203 : rnd[47:0];
    typ = fixed ? IP_TYPE : (rnd[63] ? ARP_TYPE : IP_TYPE);
    src = LOCAL_MAC;
    eff = (len > 1500) ? 1500 : len;
    for (int i = 0; i < eff; i++) pay[i] = 8'($urandom);
    bus.I_mac_dst_addr = dst;
    bus.I_mac_ttype    = typ;
    bus.I_mac_tlen     = 11'(len);
    bus.I_mac_treq     = 1'b1;

    // Reference frame: fields in wire order, pad to 46, FCS by MSB-first CRC then reflection.
    repeat (7) expq.push_back(8'h55);
    expq.push_back(8'hd5);
    for (int i = 0; i < 6; i++) expq.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) expq.push_back(src[47-8*i -: 8]);
    expq.push_back(typ[15:8]);
    expq.push_back(typ[7:0]);
    for (int i = 0; i < eff; i++) expq.push_back(pay[i]);
    for (int i = eff; i < 46; i++) expq.push_back(8'h00);
    c = 32'hFFFFFFFF;
    for (int k = 8; k < expq.size(); k++) begin
      b = expq[k];
      for (int j = 0; j < 8; j++) begin
        fb = c[31] ^ b[j];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
    end
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    fcs_e = ~r;
    for (int i = 0; i < 4; i++) expq.push_back(fcs_e[8*i +: 8]);

    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.I_mac_pause_en = 1'b0;
      if (n == rel_at) begin
        bus.I_mac_pause_time = '0;
        bus.I_mac_pause_en   = 1'b1;
        r_cyc = cyc;
      end
    end while (!bus.O_mac_tack && n < 4000);
    chk("tack_seen", {63'd0, bus.O_mac_tack}, 64'd1);
    if (!bus.O_mac_tack) begin
      bus.I_mac_treq = 1'b0;
      return;
    end
    tack_cyc = cyc;
    if (!hold) bus.I_mac_treq = 1'b0;

    nrd = 0; ndone = 0; done_idx = -1; n = 0;
    @(negedge clk);
    bus.I_mac_pause_en = 1'b0;
    chk("sof_after_tack", {63'd0, bus.O_gmii_tvalid}, 64'd1);
    sof_cyc = cyc;
    if (chk_gap && eof_cyc >= 0) chk("ifg_gap", 64'(sof_cyc - eof_cyc - 1), 64'd12);
    while (bus.O_gmii_tvalid && n < 1700) begin
      obs.push_back(bus.O_gmii_tdata);
      if (bus.O_mac_tdata_rd) nrd++;
      if (bus.O_mac_tdone) begin
        ndone++;
        done_idx = obs.size() - 1;
      end
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_async_tvalid", {63'd0, bus.O_gmii_tvalid}, 64'd0);
        @(negedge clk);
        chk("rst_outputs", {52'd0, outs()}, 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        eof_cyc = -1;
        return;
      end
      if (n == pause_at) begin
        bus.I_mac_pause_time = 22'd1000;
        bus.I_mac_pause_en   = 1'b1;
        p_cyc = cyc;
      end
      eof_cyc = cyc;
      @(negedge clk);
      n++;
      bus.I_mac_pause_en = 1'b0;
    end

    sz = obs.size();
    chk("frame_len", 64'(sz), 64'(expq.size()));
    nmis = 0;
    for (int i = 0; i < sz && i < expq.size(); i++) if (obs[i] !== expq[i]) nmis++;
    chk("frame_bytes", 64'(nmis), 64'd0);
    fcs_o = (sz >= 4) ? {obs[sz-1], obs[sz-2], obs[sz-3], obs[sz-4]} : 32'h0;
    chk("fcs", {32'd0, fcs_o}, {32'd0, fcs_e});
    chk("rd_strobes", 64'(nrd), 64'(eff));
    chk("tdone_pulses", 64'(ndone), 64'd1);
    chk("tdone_pos", 64'(done_idx), 64'(sz - 1));
  endtask

  initial begin
    int q;
    bus.I_mac_local_addr = LOCAL_MAC;
    bus.I_mac_dst_addr   = '0;
    bus.I_mac_ttype      = '0;
    bus.I_mac_tlen       = '0;
    bus.I_mac_treq       = 1'b1;
    bus.I_mac_pause_en   = 1'b0;
    bus.I_mac_pause_time = '0;
    for (int i = 0; i < 2048; i++) pay[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {52'd0, outs()}, 64'd0);
    bus.I_mac_treq = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_tack", {63'd0, bus.O_mac_tack}, 64'd0);

    // Directed lengths: nominal, short with pad, empty, clamped.
    send(64, 1'b0, 1'b1, -1, -1, -1, 1'b0);
    q = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      q += int'(bus.O_gmii_tvalid);
    end
    chk("ifg_quiet", 64'(q), 64'd0);
    send(10,   1'b0, 1'b0, -1, -1, -1, 1'b0);
    send(0,    1'b0, 1'b0, -1, -1, -1, 1'b1);
    send(1600, 1'b0, 1'b0, -1, -1, -1, 1'b1);

    // Back-to-back with treq held high.
    send(30, 1'b1, 1'b0, -1, -1, -1, 1'b1);
    send(47, 1'b1, 1'b0, -1, -1, -1, 1'b1);
    send(46, 1'b1, 1'b0, -1, -1, -1, 1'b1);
    send(50, 1'b0, 1'b0, -1, -1, -1, 1'b1);

    // Pause during a frame, then a held-off request; then pause released by time=0.
    send(64, 1'b0, 1'b0, 20, -1, -1, 1'b1);
    send(40, 1'b0, 1'b0, -1, -1, -1, GAP_AFTER_PAUSE);
`ifdef UIMAC_TX_PAUSE_EN
    chk("pause_hold_min", {63'd0, (tack_cyc - p_cyc) >= 1000}, 64'd1);
    chk("pause_hold_max", {63'd0, (tack_cyc - p_cyc) <= 1003}, 64'd1);
`endif
    send(64, 1'b0, 1'b0, 20, -1, -1, 1'b1);
    send(40, 1'b0, 1'b0, -1, 100, -1, GAP_AFTER_PAUSE);
`ifdef UIMAC_TX_PAUSE_EN
    chk("pause_release", {63'd0, (tack_cyc - r_cyc) >= 1 && (tack_cyc - r_cyc) <= 3}, 64'd1);
`endif

    // Reset in the middle of the payload, then a clean frame.
    send(200, 1'b0, 1'b0, -1, -1, 40, 1'b0);
    @(negedge clk);
    chk("post_reset_idle", {52'd0, outs()}, 64'd0);
    send(50, 1'b0, 1'b0, -1, -1, -1, 1'b0);

    for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 120)), 1'b0, 1'b0, -1, -1, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
